// File: rtl/ball_pkg.sv
// ball_pkg: shared types, constants and the per-axis step helper for the
// ball motion sequencer.
//   ball_state_t : update sequencer states (IDLE, STEP_X, STEP_Y, DONE)
//   SCREEN_W/H   : active raster size in pixels / lines
//   POS_W        : width of a position coordinate
//   axis_step()  : one frame of motion along a single axis with wall bounce
package ball_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int POS_W    = 10;

  typedef enum logic [1:0] {
    IDLE,
    STEP_X,
    STEP_Y,
    DONE
  } ball_state_t;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic             dir;   // 0 = increasing coordinate, 1 = decreasing
    logic             hit;
  } axis_step_t;

  // Arithmetic is carried out on 11 bits so that pos + speed cannot wrap and
  // the clamp comparisons are exact. At most one direction flip per call.
  function automatic axis_step_t axis_step(
    input logic [POS_W-1:0] pos,
    input logic             dir,
    input logic [10:0]      speed,
    input logic [10:0]      lim
  );
    axis_step_t  r;
    logic [10:0] p;
    p     = {1'b0, pos};
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    if (!dir) begin
      if (p + speed >= lim) begin
        r.pos = lim[POS_W-1:0];
        r.dir = 1'b1;
        r.hit = 1'b1;
      end else begin
        r.pos = POS_W'(p + speed);
      end
    end else begin
      if (p <= speed) begin
        r.pos = '0;
        r.dir = 1'b0;
        r.hit = 1'b1;
      end else begin
        r.pos = POS_W'(p - speed);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// rising_edge_detect: single-cycle pulse on a rising edge of i_sig.
//   i_clk   : clock
//   i_rst   : asynchronous active-high reset
//   i_sig   : level input (already synchronous to i_clk)
//   o_pulse : high for the cycle in which i_sig is 1 and was 0 last cycle
// After reset the detector only arms once i_sig has been sampled low, so a
// level that is already high while reset is released never produces a pulse.
module rising_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_pulse
);

  logic sig_q;
  logic armed_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sig_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sig_q <= i_sig;
      if (!i_sig) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign o_pulse = i_sig & ~sig_q & armed_q;

endmodule

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: per-frame motion sequencer for one square ball.
// On each vsync rising edge: step X (bounce on left/right wall), step Y
// (bounce on top/bottom wall), then publish hit pulses and a frame count.
//   i_clk, i_rst      : pixel clock, asynchronous active-high reset
//   i_vsync           : vsync level from the sync generator
//   o_ball_x/o_ball_y : ball top-left corner
//   o_busy            : update sequence in progress
//   o_frame_done      : one-cycle pulse when an update completes
//   o_hit_x/o_hit_y   : wall-hit pulses, coincident with o_frame_done
//   o_frame_cnt       : completed updates, wrapping
//   i_pause           : only with BALL_MOTION_PAUSE_EN; a vsync edge seen
//                       while high is consumed without an update
module ball_motion_ctrl
  import ball_pkg::*;
#(
  parameter int H_ACTIVE  = SCREEN_W,
  parameter int V_ACTIVE  = SCREEN_H,
  parameter int BALL_SIZE = 4,
  parameter int X_INIT    = 128,
  parameter int Y_INIT    = 128,
  parameter int SPEED_X   = 2,
  parameter int SPEED_Y   = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vsync,
  output logic [POS_W-1:0] o_ball_x,
  output logic [POS_W-1:0] o_ball_y,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_hit_x,
  output logic             o_hit_y,
  output logic [15:0]      o_frame_cnt
`ifdef BALL_MOTION_PAUSE_EN
  ,
  input  logic             i_pause
`endif
);

  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] SPX   = 11'(SPEED_X);
  localparam logic [10:0] SPY   = 11'(SPEED_Y);

  ball_state_t      state_q, state_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic             hit_x_q, hit_x_d, hit_y_q, hit_y_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             start;
  logic             go;
  axis_step_t       step_x, step_y;

  rising_edge_detect u_vsync_edge (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_sig   (i_vsync),
    .o_pulse (start)
  );

`ifdef BALL_MOTION_PAUSE_EN
  assign go = start & ~i_pause;
`else
  assign go = start;
`endif

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; edges arriving outside IDLE are dropped, not queued
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = STEP_X;
      STEP_X:  state_d = STEP_Y;
      STEP_Y:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy       = (state_q != IDLE);
    o_frame_done = (state_q == DONE);
    o_hit_x      = (state_q == DONE) & hit_x_q;
    o_hit_y      = (state_q == DONE) & hit_y_q;
  end

  // Datapath
  assign step_x = axis_step(x_q, dir_x_q, SPX, X_MAX);
  assign step_y = axis_step(y_q, dir_y_q, SPY, Y_MAX);

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    hit_x_d = hit_x_q;
    hit_y_d = hit_y_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          hit_x_d = 1'b0;
          hit_y_d = 1'b0;
        end
      end
      STEP_X: begin
        x_d     = step_x.pos;
        dir_x_d = step_x.dir;
        hit_x_d = step_x.hit;
      end
      STEP_Y: begin
        y_d     = step_y.pos;
        dir_y_d = step_y.dir;
        hit_y_d = step_y.hit;
      end
      DONE:    cnt_d = cnt_q + 16'd1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_q     <= POS_W'(X_INIT);
      y_q     <= POS_W'(Y_INIT);
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b0;
      hit_x_q <= 1'b0;
      hit_y_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      hit_x_q <= hit_x_d;
      hit_y_q <= hit_y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ball_x    = x_q;
  assign o_ball_y    = y_q;
  assign o_frame_cnt = cnt_q;

endmodule
